// File: rtl/serial_mag_compare_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the one-hot {greater, lesser, equal} result codes.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result bits are ordered {greater, lesser, equal}.
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  // Pack the three slice flags into the result encoding.
  function automatic logic [2:0] pack_result(input logic g, input logic l, input logic e);
    return {g, l, e};
  endfunction

endpackage

// File: rtl/serial_mag_compare_if.sv
// Request/result bundle between a requester (master) and the comparator (slave).
interface serial_mag_compare_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             greater;
  logic             lesser;
  logic             equal;

  modport master (
    output start, a, b,
    input  busy, done, greater, lesser, equal
  );

  modport slave (
    input  start, a, b,
    output busy, done, greater, lesser, equal
  );

endinterface

// File: rtl/serial_mag_compare_cmp2_slice.sv
// Combinational 2-bit unsigned comparator used for one slice per cycle.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       greater,
  output logic       lesser,
  output logic       equal
);

  assign greater = (a > b);
  assign lesser  = (a < b);
  assign equal   = (a == b);

endmodule

// File: rtl/serial_mag_compare.sv
// Serial unsigned magnitude comparator: walks the operands two bits per cycle,
// most significant slice first, and reports greater/lesser/equal.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: stop at the first unequal slice
// (variable latency). Without it every slice is visited (fixed latency) and
// the first unequal slice is remembered in a sticky decided flag.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_mag_compare_if.slave  bus
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       res;
  logic             busy_q;
  logic             done_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
  logic             decided;
  logic [2:0]       pend;
`endif

  logic [1:0] slice_a;
  logic [1:0] slice_b;
  logic       slice_gt;
  logic       slice_lt;
  logic       slice_eq;
  logic [2:0] slice_code;
  logic       last_slice;

  // Select the slice pair pointed to by idx; idx counts down from the MSB slice.
  assign slice_a    = a_q[{idx, 1'b0} +: 2];
  assign slice_b    = b_q[{idx, 1'b0} +: 2];
  assign last_slice = (idx == '0);
  assign slice_code = pack_result(slice_gt, slice_lt, slice_eq);

  cmp2_slice u_slice (
    .a       (slice_a),
    .b       (slice_b),
    .greater (slice_gt),
    .lesser  (slice_lt),
    .equal   (slice_eq)
  );

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      decided <= 1'b0;
      pend    <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            idx     <= IDX_W'(SLICES - 1);
            busy_q  <= 1'b1;
            state   <= RUN;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            decided <= 1'b0;
            pend    <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          // First unequal slice decides; an all-equal walk ends at slice 0.
          if (!slice_eq || last_slice) begin
            res    <= slice_code;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          // Visit every slice; the most significant unequal one is kept.
          if (last_slice) begin
            res    <= decided ? pend : slice_code;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
            if (!decided && !slice_eq) begin
              decided <= 1'b1;
              pend    <= slice_code;
            end
          end
`endif
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.greater = res[2];
  assign bus.lesser  = res[1];
  assign bus.equal   = res[0];

endmodule

// File: doc/serial_mag_compare.md
SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to compare; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 busy  output  1  high while a comparison is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse: result valid and newly updated.
REQ-009 greater  output  1  registered result, A > B (unsigned).
REQ-010 lesser  output  1  registered result, A < B (unsigned).
REQ-011 equal  output  1  registered result, A == B.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE or DONE with start=1 SHALL latch a/b into internal registers, set slice index to WIDTH/2-1, and go to RUN.
REQ-014 start while in RUN SHALL be ignored; latched operands and index unchanged.
REQ-015 Each RUN cycle SHALL compare exactly one 2-bit slice pair, {A[2i+1:2i], B[2i+1:2i]}, at index i, MSB slice first.
REQ-016 An unequal slice SHALL resolve the result: greater or lesser per that slice, equal=0.
REQ-017 An equal slice with i=0 SHALL resolve equal=1, greater=0, lesser=0.
REQ-018 An equal slice with i>0 SHALL decrement i and stay in RUN.
REQ-019 On resolution, result registers SHALL update on that edge and the FSM SHALL go to DONE; done=1 for exactly the one DONE cycle.
REQ-020 DONE with start=0 SHALL return to IDLE; greater/lesser/equal SHALL hold their value until the next resolution.
REQ-021 Latency: done asserted n cycles after the accepting edge, where n = number of slices examined (1..WIDTH/2).
REQ-022 After the first resolution, exactly one of greater/lesser/equal SHALL be 1; result registers SHALL not change while busy=1.
REQ-023 Arithmetic SHALL be unsigned; no operand sign interpretation.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, index 0, operand registers 0, and busy, done, greater, lesser, and equal all 0, regardless of clk.
REQ-025 Reset during RUN SHALL abandon the comparison with no done pulse; start SHALL be ignored while rst=1.

Configuration
REQ-026 Macro SERIAL_CMP_EARLY_EXIT_EN defined: resolution per REQ-016 at the first unequal slice (variable latency).
REQ-027 Macro undefined: all WIDTH/2 slices SHALL always be examined (fixed latency WIDTH/2). The result SHALL be taken from the first, most significant unequal slice, recorded in a sticky decided flag; later slices SHALL not alter it.

Structure
REQ-028 Shared package cmp_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the 3-bit result encoding constants GT/LT/EQ.
REQ-029 One sub-module cmp2_slice SHALL be purely combinational: 2-bit a/b in, greater/lesser/equal out. It SHALL be instantiated once and driven by the index-selected slice.

Verification (WIDTH=8)
REQ-030 a=0xA5, b=0x5A, start 1 cycle -> greater=1 with done 1 cycle after accept with EARLY_EXIT_EN, 4 cycles without.
REQ-031 a=0x12, b=0x13 -> lesser=1, done 4 cycles after accept in both configurations.
REQ-032 a=b=0x3C -> equal=1 after 4 cycles; then a=0x00, b=0xC0 -> lesser=1, equal=0.
REQ-033 Accept a=0x12/b=0x13, then pulse start with a=0xFF/b=0x00 during busy -> ignored, result lesser=1.
REQ-034 Assert rst during the second RUN cycle -> no done, all outputs 0 immediately; next start a=0x80/b=0x7F -> greater=1.
REQ-035 start held high through the DONE cycle with new a=0x01/b=0x02 -> back-to-back accept, second done reports lesser=1 with no idle cycle.
